// File: rtl/riscv_crypto_aes_dec_unit_pkg.sv
// Shared types and GF(2^8) helpers for the AES decrypt datapath.
// Holds op encoding, xtime, constant multiplies and field inversion.
package riscv_crypto_pkg;

  typedef enum logic {
    AES_DS  = 1'b0,
    AES_DSM = 1'b1
  } aes_op_e;

  localparam int INV_SBOX_LAT = 0;

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // c is one of 09/0B/0D/0E; any 4-bit constant works.
  function automatic logic [7:0] gf_mul_const(
    input logic [7:0] a,
    input logic [3:0] c
  );
    logic [7:0] a2, a4, a8;
    a2 = xtime(a);
    a4 = xtime(a2);
    a8 = xtime(a4);
    return (c[0] ? a  : 8'h00) ^
           (c[1] ? a2 : 8'h00) ^
           (c[2] ? a4 : 8'h00) ^
           (c[3] ? a8 : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Shared middle layer: a^254 == a^-1, with 0 -> 0.
  function automatic logic [7:0] gf_inv(
    input logic [7:0] a
  );
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

endpackage

// File: rtl/riscv_crypto_aes_dec_unit_if.sv
// Operand/result valid-ready bundle for the AES decrypt unit.
// master = issuing execute stage, slave = the unit.
interface riscv_crypto_aes_dec_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [1:0]  in_bs;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;

  modport master (
    output in_valid, in_op, in_bs,
    output in_rs1, in_rs2, in_tag,
    output out_ready,
    input  in_ready, out_valid,
    input  out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_bs,
    input  in_rs1, in_rs2, in_tag,
    input  out_ready,
    output in_ready, out_valid,
    output out_result, out_tag
  );
endinterface

// File: rtl/riscv_crypto_aes_dec_unit_sbox_inv.sv
// Combinational AES inverse S-box: x (8b) -> y = InvSbox(x) (8b).
// Inverse affine top layer, shared inversion middle, identity bottom.
module riscv_crypto_sbox_inv_aes
  import riscv_crypto_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  logic [7:0] t;

  // Inverse affine map with the 0x63 offset folded into 0x05.
  assign t = {x[6:0], x[7]} ^
             {x[4:0], x[7:5]} ^
             {x[1:0], x[7:2]} ^
             8'h05;

  assign y = gf_inv(t);

endmodule

// File: rtl/riscv_crypto_aes_dec_unit.sv
// aes32dsi/aes32dsmi unit: clk, reset, flush, bus (valid/ready slave).
// S1 = byte select + inverse S-box, S2 = InvMixColumns column + rotate/xor.
module riscv_crypto_aes_dec_unit
  import riscv_crypto_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  riscv_crypto_aes_dec_unit_if.slave bus
);

  logic        s1_valid;
  logic [7:0]  s1_s;
  aes_op_e     s1_op;
  logic [1:0]  s1_bs;
  logic [31:0] s1_rs1;
  logic [3:0]  s1_tag;

  logic [7:0]  sel;
  logic [7:0]  sb;
  logic        s1_adv;
  logic        s2_adv;
  logic        acc;
  logic [31:0] w;
  logic [31:0] rot;
  logic [31:0] res;

  assign sel = bus.in_rs2[{bus.in_bs, 3'b000} +: 8];

  riscv_crypto_sbox_inv_aes u_sbox (
    .x (sel),
    .y (sb)
  );

  assign s1_adv       = ~s1_valid | s2_adv;
  assign bus.in_ready = s1_adv & ~flush;
  assign acc          = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       s1_valid <= 1'b0;
    else if (flush)  s1_valid <= 1'b0;
    else if (s1_adv) s1_valid <= acc;
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      s1_s   <= sb;
      s1_op  <= aes_op_e'(bus.in_op);
      s1_bs  <= bus.in_bs;
      s1_rs1 <= bus.in_rs1;
      s1_tag <= bus.in_tag;
    end
  end

  always_comb begin
    w = 32'h0;
    unique case (s1_op)
      AES_DS:  w = {24'h0, s1_s};
      AES_DSM: w = {gf_mul_const(s1_s, 4'hB),
                    gf_mul_const(s1_s, 4'hD),
                    gf_mul_const(s1_s, 4'h9),
                    gf_mul_const(s1_s, 4'hE)};
      default: w = 32'h0;
    endcase
  end

  always_comb begin
    rot = w;
    unique case (s1_bs)
      2'd0: rot = w;
      2'd1: rot = {w[23:0], w[31:24]};
      2'd2: rot = {w[15:0], w[31:16]};
      2'd3: rot = {w[7:0],  w[31:8]};
      default: rot = w;
    endcase
  end

  assign res = s1_rs1 ^ rot;

  if (REG_OUT) begin : g_reg
    logic        ov;
    logic [31:0] ores;
    logic [3:0]  otag;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ov   <= 1'b0;
        ores <= 32'h0;
        otag <= 4'h0;
      end else if (flush) begin
        ov <= 1'b0;
      end else if (s2_adv) begin
        ov <= s1_valid;
        if (s1_valid) begin
          ores <= res;
          otag <= s1_tag;
        end
      end
    end

    assign s2_adv         = ~ov | bus.out_ready;
    assign bus.out_valid  = ov;
    assign bus.out_result = ores;
    assign bus.out_tag    = otag;
  end else begin : g_comb
    assign s2_adv         = bus.out_ready;
    assign bus.out_valid  = s1_valid;
    assign bus.out_result = res;
    assign bus.out_tag    = s1_tag;
  end

endmodule

// File: tb/tb_riscv_crypto_aes_dec_unit.sv
// Self-checking bench for riscv_crypto_aes_dec_unit.
// Reference: brute-force GF inverse + forward affine, inverted into a table.
module tb_riscv_crypto_aes_dec_unit;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  riscv_crypto_aes_dec_unit_if bus ();

  riscv_crypto_aes_dec_unit #(.REG_OUT(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_out = 0;
  int last_out_cyc = 0;

  logic [7:0]  inv_tab [256];
  logic [31:0] q_res [$];
  logic [3:0]  q_tag [$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [3:0]  prev_tag;
  bit          drv_done;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h11B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = (v << n) | (v >> (8 - n));
    return r;
  endfunction

  task automatic build_tab();
    logic [7:0] a, b, f;
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      b = 8'h00;
      if (a != 8'h00)
        for (int c = 1; c < 256; c++)
          if (gmul(a, 8'(c)) == 8'h01) b = 8'(c);
      f = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
      inv_tab[f] = a;
    end
  endtask

  function automatic logic [31:0] model(input logic op, input logic [1:0] bs,
                                        input logic [31:0] r1, input logic [31:0] r2);
    logic [7:0]  s;
    logic [31:0] w, rot;
    int sh;
    sh = 8 * int'(bs);
    s = inv_tab[8'(r2 >> sh)];
    if (op)
      w = {gmul(s, 8'h0B), gmul(s, 8'h0D), gmul(s, 8'h09), gmul(s, 8'h0E)};
    else
      w = {24'h0, s};
    rot = (sh == 0) ? w : ((w << sh) | (w >> (32 - sh)));
    return r1 ^ rot;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset || flush) begin
      q_res.delete();
      q_tag.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.out_valid), 32'h1);
        chk("hold_result", bus.out_result, prev_res);
        chk("hold_tag", 32'(bus.out_tag), 32'(prev_tag));
      end
      if (bus.out_valid) begin
        if (q_res.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_out: got result %h tag %h, expected none",
                   bus.out_result, bus.out_tag);
        end else begin
          chk("result", bus.out_result, q_res[0]);
          chk("tag", 32'(bus.out_tag), 32'(q_tag[0]));
          if (bus.out_ready) begin
            void'(q_res.pop_front());
            void'(q_tag.pop_front());
            n_out++;
            last_out_cyc = cyc;
          end
        end
      end
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_res = bus.out_result;
      prev_tag = bus.out_tag;
      if (bus.in_valid && bus.in_ready) begin
        q_res.push_back(model(bus.in_op, bus.in_bs, bus.in_rs1, bus.in_rs2));
        q_tag.push_back(bus.in_tag);
      end
    end
  end

  task automatic send(input logic op, input logic [1:0] bs, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [3:0] tg);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_bs = bs;
    bus.in_rs1 = r1;
    bus.in_rs2 = r2;
    bus.in_tag = tg;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no accept, expected accept within 200 cycles");
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 50);
  endtask

  task automatic directed(input string nm, input logic op, input logic [1:0] bs,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] exp);
    int n;
    send(op, bs, r1, r2, 4'hA);
    wait_out(n);
    chk({nm, "_latency"}, n, 2);
    chk(nm, bus.out_result, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    int c0, base, stalls, n;
    logic [31:0] r;
    logic [3:0] tg;

    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = 1'b0;
    bus.in_bs = 2'd0;
    bus.in_rs1 = 32'h0;
    bus.in_rs2 = 32'h0;
    bus.in_tag = 4'h0;
    bus.out_ready = 1'b1;

    build_tab();
    chk("tab_00", 32'(inv_tab[8'h00]), 32'h52);
    chk("tab_01", 32'(inv_tab[8'h01]), 32'h09);
    chk("tab_02", 32'(inv_tab[8'h02]), 32'h6A);
    chk("tab_63", 32'(inv_tab[8'h63]), 32'h00);
    chk("tab_7c", 32'(inv_tab[8'h7C]), 32'h01);
    chk("tab_ff", 32'(inv_tab[8'hFF]), 32'h7D);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_result", bus.out_result, 32'h0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;

    directed("dsi_bs0_zero", 1'b0, 2'd0, 32'h0, 32'h0, 32'h00000052);
    directed("dsi_bs3", 1'b0, 2'd3, 32'h12345678, 32'h01000000, 32'h1B345678);
    directed("dsmi_bs0", 1'b1, 2'd0, 32'h0, 32'h0, 32'h50A7F451);
    directed("dsmi_bs1", 1'b1, 2'd1, 32'h0, 32'h0, 32'hA7F45150);

    // Exhaustive back-to-back aes32dsi over every low byte.
    c0 = cyc;
    base = n_out;
    stalls = 0;
    for (int x = 0; x < 256; x++) begin
      r = $urandom;
      r[7:0] = 8'(x);
      bus.in_valid = 1'b1;
      bus.in_op = 1'b0;
      bus.in_bs = 2'd0;
      bus.in_rs1 = 32'h0;
      bus.in_rs2 = r;
      bus.in_tag = 4'(x);
      @(negedge clk);
      if (!bus.in_ready) stalls++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && n_out - base < 256; i++) begin
      @(posedge clk);
      #1;
    end
    chk("burst_stalls", stalls, 0);
    chk("burst_count", n_out - base, 256);
    chk("burst_cycles", last_out_cyc - c0, 257);

    // Random ops under random backpressure.
    base = n_out;
    drv_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 200; k++) begin
          tg = 4'(k);
          send(1'($urandom), 2'($urandom), $urandom, $urandom, tg);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom);
        end
      end
    join
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && q_res.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_drained", q_res.size(), 0);
    chk("bp_count", n_out - base, 200);

    // Flush a full, stalled pipe with a beat on the input.
    bus.out_ready = 1'b0;
    send(1'b1, 2'd2, 32'h11111111, 32'h00330000, 4'h1);
    send(1'b0, 2'd1, 32'h22222222, 32'h00004400, 4'h2);
    bus.in_valid = 1'b1;
    bus.in_tag = 4'h3;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(bus.in_ready), 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    directed("post_flush", 1'b0, 2'd3, 32'h12345678, 32'h01000000, 32'h1B345678);

    // Asynchronous reset of a full, stalled pipe.
    bus.out_ready = 1'b0;
    send(1'b1, 2'd0, 32'hDEADBEEF, 32'h000000AB, 4'h4);
    send(1'b1, 2'd3, 32'hCAFEF00D, 32'hCD000000, 4'h5);
    bus.in_valid = 1'b1;
    bus.in_tag = 4'h6;
    #2;
    reset = 1'b1;
    #1;
    chk("areset_out_valid", 32'(bus.out_valid), 32'h0);
    chk("areset_out_result", bus.out_result, 32'h0);
    chk("areset_out_tag", 32'(bus.out_tag), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("areset_in_ready", 32'(bus.in_ready), 32'h1);
    chk("areset_valid_after", 32'(bus.out_valid), 32'h0);
    @(posedge clk);
    #1;
    directed("post_reset", 1'b1, 2'd0, 32'h0, 32'h0, 32'h50A7F451);

    wait_out(n);
    chk("final_empty", q_res.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_crypto_aes_dec_unit.md
Name: riscv_crypto_aes_dec_unit

Overview:
Pipelined execution unit for the RV32 scalar AES decryption instructions aes32dsi (inverse SubBytes only) and aes32dsmi (inverse SubBytes plus InvMixColumns), completing the decrypt direction of the crypto datapath. It sits beside the encrypt-side S-box path as a functional unit of the RS5 execute stage. Operands arrive through a valid/ready handshake, and the unit returns the 32-bit result after a fixed 2-cycle latency. It sustains one operation per cycle and stalls under backpressure.

Parameters:
REG_OUT, 1, 1 = stage-2 result registered (latency 2); 0 = stage 2 combinational from stage-1 register (latency 1)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of all in-flight operations
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept a beat this cycle
in_op  input  1  0 = aes32dsi, 1 = aes32dsmi
in_bs  input  2  byte select
in_rs1  input  32  accumulator operand
in_rs2  input  32  source word
in_tag  input  4  opaque ID, returned with the result
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_result  output  32  rs1 ^ rol(f(inv_sbox(rs2[8*bs+:8])), 8*bs)
out_tag  output  4  tag of the result

Behaviour:
- Reset (asynchronous, active-high): all stage valids = 0; out_valid = 0; out_result = 0; out_tag = 0; in_ready = 1 once reset is released.
- Stage 1 (S1), on an accepted beat (in_valid & in_ready):
  - select byte x = rs2[8*bs+7 : 8*bs];
  - compute s = inv_sbox(x);
  - register s, op, bs, rs1 and tag.
- Stage 2 (S2):
  - If op = 0, column word w = {24'h0, s}.
  - If op = 1, w = {0B·s, 0D·s, 09·s, 0E·s}, listed as bytes [31:24] down to [7:0], with multiplication in GF(2^8) mod 0x11B.
  - Result = rs1 ^ rol32(w, 8*bs).
  - Register result and tag into the output register.
- Latency: with REG_OUT = 1, result is visible 2 cycles after acceptance. Throughput is 1 op/cycle while out_ready = 1.
- Backpressure: the pipeline advances only when the downstream slot is empty or being drained.
  - Output slot: advances when ~out_valid | out_ready.
  - S1: advances when ~s1_valid | s2_advance.
  - in_ready = ~s1_valid | s2_advance (combinational; no dependence on in_valid).
- Outputs stay stable while out_valid & ~out_ready. No beat is dropped or duplicated.
- Simultaneous accept and drain in the same cycle: a full pipe keeps streaming with no bubble.
- flush: clears s1_valid and out_valid at the next edge. An input beat presented in the same cycle is discarded, and in_ready is forced to 0 during flush.
- Reset asserted mid-operation clears all valids immediately (asynchronously). Datapath registers need no reset except out_result and out_tag.
- Width rules:
  - all XOR/rotate arithmetic is 32-bit modulo;
  - rol by 0/8/16/24 only;
  - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1B : 8'h00).
- inv_sbox follows the Boyar–Peralta-style structure: an inverse top linear layer, the shared nonlinear GF(256) inversion middle layer, and an inverse bottom linear layer with constant folding. It is purely combinational and bit-exact to the FIPS-197 InvSbox for all 256 inputs.

Decomposition:
- Package riscv_crypto_pkg holds:
  - typedef aes_op_e {AES_DS = 1'b0, AES_DSM = 1'b1};
  - function xtime;
  - function gf_mul_const (multiplies by 09/0B/0D/0E);
  - localparam INV_SBOX_LAT = 0.
- Sub-module riscv_crypto_sbox_inv_aes (8-in/8-out combinational inverse S-box) is instantiated once in S1. It reuses the existing shared middle layer; only its inverse top and bottom linear layers are new.

Test Plan:
- aes32dsi, bs=0, rs2=0x00000000, rs1=0x00000000 -> out_result=0x00000052 two cycles after acceptance.
- aes32dsi, bs=3, rs2=0x01000000, rs1=0x12345678 -> out_result=0x1B345678 (InvSbox(0x01)=0x09).
- aes32dsmi, bs=0, rs2=0, rs1=0 -> 0x50A7F451; same operands with bs=1 -> 0xA7F45150.
- Exhaustive: for all x in 0..255, aes32dsi bs=0, rs1=0 -> low byte matches the FIPS-197 InvSbox table and upper bytes are 0. Back-to-back issue must give 256 results in 257 cycles.
- Backpressure: stream 8 ops with out_ready toggled pseudo-randomly -> results arrive in order with matching tags, no loss or duplication, and outputs stable while stalled.
- Hold a full pipe, then assert flush (and separately reset) together with in_valid -> out_valid=0 next cycle (immediately for reset), the flushed input is not accepted, and the next fresh op produces the correct result.
